// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and byte-lane geometry.
// Optional checksum stage is enabled by defining BOOT_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        RECV  = 3'd0,
        WRITE = 3'd1,
        DONE  = 3'd2,
        CHECK = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/boot_word_assembler.sv
// Collects accepted bytes little-endian into a 32-bit word; o_word merges the byte
// being accepted this cycle so the completed word is available on the 4th byte.
module boot_word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [31:0]       r_lanes;
    logic [LANE_W-1:0] r_byteIdx;
    logic [31:0]       w_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes   <= '0;
            r_byteIdx <= '0;
        end else if (i_clear) begin
            r_lanes   <= '0;
            r_byteIdx <= '0;
        end else if (i_accept) begin
            r_lanes[{r_byteIdx, 3'b000} +: 8] <= i_byte;
            r_byteIdx                         <= r_byteIdx + LANE_W'(1);
        end
    end

    always_comb begin
        w_word = r_lanes;
        w_word[{r_byteIdx, 3'b000} +: 8] = i_byte;
    end

    assign o_word      = w_word;
    assign o_word_full = i_accept && (r_byteIdx == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Streams a program byte-wise into memory, holding the core in reset until loaded.
// Define BOOT_CHECKSUM_EN to add a trailing XOR checksum byte (CHECK/ERROR states).
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 18,
    parameter int unsigned CNT_W      = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    input  logic        i_load_start,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    output logic        o_cpu_rst_n,
    output logic        o_done,
    output logic        o_err
);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_wordCnt;
    logic             r_byteReady;
    logic             r_memWe;
    logic [31:0]      r_memAddr;
    logic [31:0]      r_memWd;
    logic             r_cpuRstN;
    logic             r_done;
    logic             w_accept;
    logic             w_dataAccept;
    logic             w_reload;
    logic             w_lastWord;
    logic             w_wordFull;
    logic [31:0]      w_word;

    assign w_accept     = i_byte_valid && r_byteReady;
    assign w_dataAccept = w_accept && (r_state == RECV);
    assign w_reload     = i_load_start && ((r_state == DONE) || (r_state == ERROR));
    assign w_lastWord   = (r_wordCnt + CNT_W'(1)) == CNT_W'(WORD_COUNT);

    boot_word_assembler u_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_reload),
        .i_accept    (w_dataAccept),
        .i_byte      (i_byte_in),
        .o_word      (w_word),
        .o_word_full (w_wordFull)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_reload) begin
            r_csum <= '0;
        end else if (w_dataAccept) begin
            r_csum <= r_csum ^ i_byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_nextState == ERROR);
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RECV;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RECV:  if (w_wordFull) w_nextState = WRITE;
            WRITE: begin
                if (w_lastWord) begin
`ifdef BOOT_CHECKSUM_EN
                    w_nextState = CHECK;
`else
                    w_nextState = DONE;
`endif
                end else begin
                    w_nextState = RECV;
                end
            end
            DONE:  if (i_load_start) w_nextState = RECV;
`ifdef BOOT_CHECKSUM_EN
            CHECK: if (w_accept) w_nextState = (i_byte_in == r_csum) ? DONE : ERROR;
            ERROR: if (i_load_start) w_nextState = RECV;
`endif
            default: w_nextState = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wordCnt <= '0;
        end else if (w_reload) begin
            r_wordCnt <= '0;
        end else if (r_state == WRITE) begin
            r_wordCnt <= r_wordCnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byteReady <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= BASE_ADDR;
            r_memWd     <= '0;
            r_cpuRstN   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_byteReady <= (w_nextState == RECV) || (w_nextState == CHECK);
            r_memWe     <= (w_nextState == WRITE);
            r_cpuRstN   <= (w_nextState == DONE);
            r_done      <= (w_nextState == DONE);
            if (w_wordFull) begin
                r_memAddr <= BASE_ADDR + (32'(r_wordCnt) << 2);
                r_memWd   <= w_word;
            end
        end
    end

    assign o_byte_ready = r_byteReady;
    assign o_mem_we     = r_memWe;
    assign o_mem_addr   = r_memAddr;
    assign o_mem_wd     = r_memWd;
    assign o_cpu_rst_n  = r_cpuRstN;
    assign o_done       = r_done;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a 2-word instance for handshake/reset/reload cases
// and an 18-word instance for a full program. Honours BOOT_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byteIn = 8'h00;
    logic        byteValid = 1'b0;
    logic        byteValid18 = 1'b0;
    logic        loadStart = 1'b0;

    logic        byteReady, memWe, cpuRstN, done, err;
    logic [31:0] memAddr, memWd;
    logic        byteReady18, memWe18, cpuRstN18, done18, err18;
    logic [31:0] memAddr18, memWd18;

    int          nChecks = 0;
    int          nErrors = 0;

    logic [31:0] wrAddr [64];
    logic [31:0] wrData [64];
    int          wrCount = 0;
    logic [31:0] memModel [32];
    logic [31:0] wr18Addr [32];
    logic [31:0] wr18Data [32];
    int          wr18Count = 0;

    logic [31:0] progA [2];
    logic [31:0] prog18 [18];

    boot_loader #(.WORD_COUNT(2), .CNT_W(8), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_byte_in(byteIn), .i_byte_valid(byteValid),
        .o_byte_ready(byteReady), .i_load_start(loadStart), .o_mem_we(memWe),
        .o_mem_addr(memAddr), .o_mem_wd(memWd), .o_cpu_rst_n(cpuRstN),
        .o_done(done), .o_err(err)
    );

    boot_loader #(.WORD_COUNT(18), .CNT_W(8), .BASE_ADDR(32'h0)) u_dut18 (
        .clk(clk), .rst_n(rst_n), .i_byte_in(byteIn), .i_byte_valid(byteValid18),
        .o_byte_ready(byteReady18), .i_load_start(1'b0), .o_mem_we(memWe18),
        .o_mem_addr(memAddr18), .o_mem_wd(memWd18), .o_cpu_rst_n(cpuRstN18),
        .o_done(done18), .o_err(err18)
    );

    always #5 clk = ~clk;

    // Log every memory write of both instances mid-cycle, when the strobe is stable.
    always @(negedge clk) begin
        if (memWe) begin
            if (wrCount < 64) begin
                wrAddr[wrCount] = memAddr;
                wrData[wrCount] = memWd;
            end
            memModel[memAddr[6:2]] = memWd;
            wrCount++;
        end
        if (memWe18) begin
            if (wr18Count < 32) begin
                wr18Addr[wr18Count] = memAddr18;
                wr18Data[wr18Count] = memWd18;
            end
            wr18Count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offers one byte and returns 1ns after the edge on which it was accepted.
    task automatic applyStimulus(input logic [7:0] b, input bit big);
        int guard;
        logic rdy;
        guard = 0;
        byteIn = b;
        if (big) byteValid18 = 1'b1; else byteValid = 1'b1;
        rdy = big ? byteReady18 : byteReady;
        while (rdy !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
            rdy = big ? byteReady18 : byteReady;
        end
        if (guard >= 40) checkOutput("readyTimeout", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        byteValid   = 1'b0;
        byteValid18 = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit big);
        for (int j = 0; j < 4; j++) applyStimulus(w[j*8 +: 8], big);
    endtask

    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic pulseLoad();
        loadStart = 1'b1;
        @(posedge clk); #1;
        loadStart = 1'b0;
    endtask

    function automatic logic [7:0] progXor(input bit big);
        logic [7:0] x;
        x = 8'h00;
        if (big) begin
            for (int i = 0; i < 18; i++) x = x ^ prog18[i][7:0] ^ prog18[i][15:8] ^ prog18[i][23:16] ^ prog18[i][31:24];
        end else begin
            for (int i = 0; i < 2; i++) x = x ^ progA[i][7:0] ^ progA[i][15:8] ^ progA[i][23:16] ^ progA[i][31:24];
        end
        return x;
    endfunction

    // Called 1ns after the final WRITE edge; leaves the loader in its terminal state.
    task automatic finishLoad(input bit big, input bit goodSum);
        @(posedge clk); #1;
`ifdef BOOT_CHECKSUM_EN
        checkOutput("csumReady", {31'b0, big ? byteReady18 : byteReady}, 32'd1);
        applyStimulus(goodSum ? progXor(big) : (progXor(big) ^ 8'h01), big);
`else
        if (!goodSum) $display("[TB] checksum stage not built; bad-sum request ignored");
`endif
    endtask

    initial begin
        int base;
        progA[0] = 32'h1234_5678;
        progA[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 18; i++)
            prog18[i] = {8'(16 + 4*i + 3), 8'(16 + 4*i + 2), 8'(16 + 4*i + 1), 8'(16 + 4*i)};

        // Reset values while rst_n is held low
        #12;
        checkOutput("rstByteReady", {31'b0, byteReady}, 32'd0);
        checkOutput("rstMemWe",     {31'b0, memWe},     32'd0);
        checkOutput("rstMemAddr",   memAddr,            32'h0);
        checkOutput("rstMemWd",     memWd,              32'h0);
        checkOutput("rstCpuRstN",   {31'b0, cpuRstN},   32'd0);
        checkOutput("rstDone",      {31'b0, done},      32'd0);
        checkOutput("rstErr",       {31'b0, err},       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nominal two-word load
        $display("[TB] nominal load");
        base = wrCount;
        sendWord(progA[0], 1'b0);
        checkOutput("w0We",        {31'b0, memWe},     32'd1);
        checkOutput("w0Addr",      memAddr,            32'h0);
        checkOutput("w0Data",      memWd,              32'h1234_5678);
        checkOutput("w0ReadyLow",  {31'b0, byteReady}, 32'd0);
        sendWord(progA[1], 1'b0);
        checkOutput("w1We",        {31'b0, memWe},     32'd1);
        checkOutput("w1Addr",      memAddr,            32'h4);
        checkOutput("w1Data",      memWd,              32'hDEAD_BEEF);
        checkOutput("w1CpuHeld",   {31'b0, cpuRstN},   32'd0);
        finishLoad(1'b0, 1'b1);
        checkOutput("nomWeOff",    {31'b0, memWe},     32'd0);
        checkOutput("nomCpuRstN",  {31'b0, cpuRstN},   32'd1);
        checkOutput("nomDone",     {31'b0, done},      32'd1);
        checkOutput("nomErr",      {31'b0, err},       32'd0);
        checkOutput("nomDoneReady", {31'b0, byteReady}, 32'd0);
        checkOutput("nomWrites",   32'(wrCount - base), 32'd2);

        // Stray bytes in DONE are ignored
        byteIn = 8'h55; byteValid = 1'b1;
        waitCycles(3);
        byteValid = 1'b0;
        checkOutput("strayWrites", 32'(wrCount - base), 32'd2);
        checkOutput("strayDone",   {31'b0, done},       32'd1);

        // Reload from DONE; a load_start during RECV must not disturb the load
        $display("[TB] reload");
        pulseLoad();
        checkOutput("reloadCpuRstN", {31'b0, cpuRstN},   32'd0);
        checkOutput("reloadDone",    {31'b0, done},      32'd0);
        checkOutput("reloadReady",   {31'b0, byteReady}, 32'd1);
        base = wrCount;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        pulseLoad();
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b0);
        sendWord(32'h0807_0605, 1'b0);
        progA[0] = 32'h0403_0201;
        progA[1] = 32'h0807_0605;
        finishLoad(1'b0, 1'b1);
        checkOutput("reloadWrites", 32'(wrCount - base), 32'd2);
        checkOutput("reloadAddr0",  wrAddr[base],        32'h0);
        checkOutput("reloadData0",  wrData[base],        32'h0403_0201);
        checkOutput("reloadAddr1",  wrAddr[base+1],      32'h4);
        checkOutput("reloadData1",  wrData[base+1],      32'h0807_0605);
        checkOutput("reloadDone2",  {31'b0, done},       32'd1);
        progA[0] = 32'h1234_5678;
        progA[1] = 32'hDEAD_BEEF;

        // Source stalls for 7 cycles in the middle of the first word
        $display("[TB] stalled source");
        doReset();
        base = wrCount;
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h34, 1'b0);
        waitCycles(7);
        checkOutput("stallNoWrite", 32'(wrCount - base), 32'd0);
        applyStimulus(8'h12, 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b0);
        finishLoad(1'b0, 1'b1);
        checkOutput("stallWrites", 32'(wrCount - base), 32'd2);
        checkOutput("stallAddr0",  wrAddr[base],        32'h0);
        checkOutput("stallData0",  wrData[base],        32'h1234_5678);
        checkOutput("stallData1",  wrData[base+1],      32'hDEAD_BEEF);
        checkOutput("stallDone",   {31'b0, done},       32'd1);

        // Reset asserted after six bytes; outputs must clear without a clock edge
        $display("[TB] reset mid-load");
        doReset();
        base = wrCount;
        memModel[0] = 32'hFFFF_FFFF;
        memModel[1] = 32'hFFFF_FFFF;
        sendWord(32'h1234_5678, 1'b0);
        applyStimulus(8'hEF, 1'b0);
        applyStimulus(8'hBE, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstWd",    memWd,               32'h0);
        checkOutput("midRstReady", {31'b0, byteReady},  32'd0);
        checkOutput("midRstWrites", 32'(wrCount - base), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sendWord(32'h1234_5678, 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b0);
        finishLoad(1'b0, 1'b1);
        checkOutput("midRstRestart", wrAddr[base+1], 32'h0);
        checkOutput("midRstMem0",    memModel[0],    32'h1234_5678);
        checkOutput("midRstMem1",    memModel[1],    32'hDEAD_BEEF);
        checkOutput("midRstDone",    {31'b0, done},  32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum byte lands in ERROR and keeps the core in reset
        $display("[TB] checksum failure");
        doReset();
        sendWord(32'h1234_5678, 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b0);
        finishLoad(1'b0, 1'b0);
        checkOutput("csumErr",     {31'b0, err},     32'd1);
        checkOutput("csumCpuRstN", {31'b0, cpuRstN}, 32'd0);
        checkOutput("csumDone",    {31'b0, done},    32'd0);
        pulseLoad();
        checkOutput("csumErrClear", {31'b0, err},       32'd0);
        checkOutput("csumReload",   {31'b0, byteReady}, 32'd1);
`endif

        // Full 18-word program on the second instance
        $display("[TB] full program");
        for (int i = 0; i < 18; i++) sendWord(prog18[i], 1'b1);
        finishLoad(1'b1, 1'b1);
        checkOutput("fullWrites", 32'(wr18Count), 32'd18);
        for (int i = 0; i < 18; i++) begin
            checkOutput("fullAddr", wr18Addr[i], 32'(4*i));
            checkOutput("fullData", wr18Data[i], prog18[i]);
        end
        checkOutput("fullCpuRstN", {31'b0, cpuRstN18}, 32'd1);
        checkOutput("fullDone",    {31'b0, done18},    32'd1);
        checkOutput("fullErr",     {31'b0, err18},     32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
